// File: rtl/mealy_seq_detect_pkg.sv
// Shared defaults and fill-state encoding for the Mealy serial-pattern detector.
package mealy_seq_detect_pkg;

    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_CNT_W   = 8;
    localparam logic [DEF_PAT_LEN-1:0] DEF_RST_PAT = 4'b1011;

    // FILL while fewer than PAT_LEN-1 history bits are held, ARMED once full.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_e;

    // Width of a counter that must hold 0..pat_len-1.
    function automatic int fill_w(input int pat_len);
        return (pat_len <= 2) ? 1 : $clog2(pat_len);
    endfunction

endpackage

// File: rtl/mealy_seq_detect_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment yields one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = inc ? W'(1) : '0;
        end else if (inc && (q_reg != '1)) begin
            q_next = q_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mealy_seq_detect.sv
// Programmable Mealy serial-pattern detector with qualifier, overlap control and
// saturating match counter; det reacts in the same cycle as the final bit.
module mealy_seq_detect
    import mealy_seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(DEF_RST_PAT),
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               x,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   det_count,
    output logic               armed
);

    localparam int HW = PAT_LEN - 1;
    localparam int FW = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pattern_reg, pattern_next;
    logic [HW-1:0]      hist_reg, hist_next;
    logic [FW-1:0]      fill_reg, fill_next;
    fill_state_e        state_reg, state_next;

    logic [HW-1:0] hist_shift;
    logic          match;

    // Dropping the top bit of {hist, x} is the one-bit shift with x entering at bit 0.
    assign hist_shift = HW'({hist_reg, x});
    assign match      = ({hist_reg, x} == pattern_reg);

    always_comb begin
        pattern_next = pattern_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        det          = 1'b0;

        if (pat_load) begin
            pattern_next = pat_in;
            hist_next    = '0;
            fill_next    = '0;
        end else if (in_valid) begin
            det = (state_reg == ARMED) && match && !rst;
            if (det && !overlap) begin
                hist_next = '0;
                fill_next = '0;
            end else begin
                hist_next = hist_shift;
                if (fill_reg != FILL_MAX) begin
                    fill_next = fill_reg + FW'(1);
                end
            end
        end

        state_next = (fill_next == FILL_MAX) ? ARMED : FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_reg <= RST_PAT;
            hist_reg    <= '0;
            fill_reg    <= '0;
            state_reg   <= FILL;
        end else begin
            pattern_reg <= pattern_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            state_reg   <= state_next;
        end
    end

    assign armed = (state_reg == ARMED);

    sat_counter #(
        .W(CNT_W)
    ) u_count (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (det),
        .q   (det_count)
    );

endmodule
